beat_tracker: RTL

- Audio-domain stage that sits directly upstream of the dancer motion manager.
- Consumes the per-sample audio power stream and decides when a beat occurs, using an energy-over-running-average detector with a refractory holdoff.
- Produces a one-cycle beat pulse, a "beating" level and a measured beat period in audio clocks.
- The motion manager uses these to flip dance direction and gate movement.

---
 rtl/beat_tracker_if.sv | 36 +++
 rtl/beat_tracker.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/beat_tracker_if.sv
// ----------------------------------------------------------------------------
// beat_tracker_if
//   Bundle between the audio power source and the beat tracker.
//   The master drives the power stream and watches the beat results.
//   The slave (beat_tracker) consumes the power stream and produces the
//   results.
//
//   Signals:
//     iPow               POW_W     unsigned audio power sample
//     iPow_valid         1         iPow is valid this cycle
//     beatHit            1         one-cycle beat pulse
//     beating            1         a regular beat is currently present
//     aud_tics_per_beat  PERIOD_W  last measured beat period, in aud_clk cycles
//     period_valid       1         aud_tics_per_beat holds a measurement
// ----------------------------------------------------------------------------
interface beat_tracker_if #(
    parameter int POW_W    = 11,
    parameter int PERIOD_W = 32
);
    logic [POW_W-1:0]    iPow;
    logic                iPow_valid;
    logic                beatHit;
    logic                beating;
    logic [PERIOD_W-1:0] aud_tics_per_beat;
    logic                period_valid;

    modport master (
        output iPow, iPow_valid,
        input  beatHit, beating, aud_tics_per_beat, period_valid
    );

    modport slave (
        input  iPow, iPow_valid,
        output beatHit, beating, aud_tics_per_beat, period_valid
    );
endinterface

// File: rtl/beat_tracker.sv
// ----------------------------------------------------------------------------
// beat_tracker
//   Decides when a beat occurs in the audio power stream. A sample counts as
//   a beat when it clearly exceeds a running average of the stream and the
//   tracker is not inside the holdoff window that follows the previous beat.
//   Publishes a one-cycle beat pulse, a "beating" level and the measured
//   beat period for the dancer motion manager.
//
//   Ports:
//     aud_clk   in   audio clock, the only clock
//     reset_n   in   asynchronous active-low reset
//     bus       slave side of beat_tracker_if (power stream in, results out)
//
//   Build option:
//     BEAT_PERIOD_AVG_EN  when defined, the published period is a running
//                         two-point average of measured periods instead of
//                         the raw last period.
// ----------------------------------------------------------------------------
module beat_tracker #(
    parameter int POW_W        = 11,
    parameter int AVG_SHIFT    = 6,
    parameter int THRESH_NUM   = 3,
    parameter int THRESH_SHIFT = 1,
    parameter int MIN_POW      = 64,
    parameter int WARMUP       = 256,
    parameter int HOLDOFF      = 4096,
    parameter int TIMEOUT      = 65536,
    parameter int PERIOD_W     = 32
) (
    input  logic           aud_clk,
    input  logic           reset_n,
    beat_tracker_if.slave  bus
);

    localparam int ACC_W  = POW_W + AVG_SHIFT;
    localparam int CMP_W  = POW_W + THRESH_SHIFT + 3;
    localparam int WARM_W = $clog2(WARMUP + 1);
    localparam int K_W    = PERIOD_W + 1;

    localparam logic [WARM_W-1:0] WARM_FULL = WARM_W'(WARMUP);
    localparam logic [K_W-1:0]    HOLD_K    = K_W'(HOLDOFF);
    localparam logic [K_W-1:0]    TIMEOUT_K = K_W'(TIMEOUT);
    localparam logic [POW_W-1:0]  MIN_P     = POW_W'(MIN_POW);

    typedef enum logic {LISTEN, HOLD} state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [WARM_W-1:0]   warm_q, warm_d;
    logic [PERIOD_W-1:0] tic_q, tic_d;
    logic                had_q, had_d;
    logic                beatHit_q, beatHit_d;
    logic                beating_q, beating_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                pvalid_q, pvalid_d;

    logic [POW_W-1:0]    avg;
    logic [CMP_W-1:0]    powScaled;
    logic [CMP_W-1:0]    avgScaled;
    logic                warmed;
    logic                detectCond;
    logic [K_W-1:0]      k;
`ifdef BEAT_PERIOD_AVG_EN
    logic [K_W-1:0]      periodSum;
`endif

    // Threshold test uses the average as it stood before this sample is
    // folded in; both sides are widened so neither the shift nor the
    // multiply can truncate.
    assign avg        = POW_W'(acc_q >> AVG_SHIFT);
    assign powScaled  = CMP_W'(bus.iPow) << THRESH_SHIFT;
    assign avgScaled  = CMP_W'(avg) * CMP_W'(THRESH_NUM);
    assign warmed     = (warm_q == WARM_FULL);
    assign detectCond = bus.iPow_valid && warmed && (bus.iPow >= MIN_P) &&
                        (powScaled > avgScaled);

    // k is the number of edges since the previous beat including this one;
    // one bit wider than tic_q so a saturated counter still compares cleanly.
    assign k = {1'b0, tic_q} + K_W'(1);

`ifdef BEAT_PERIOD_AVG_EN
    assign periodSum = {1'b0, period_q} + k;
`endif

    // Next-state logic: the LISTEN/HOLD machine plus everything that moves
    // with it. A beat is the LISTEN->HOLD transition itself, so beatHit_d
    // marks the edge on which the period and timeout bookkeeping restart.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        warm_d    = warm_q;
        tic_d     = tic_q;
        had_d     = had_q;
        beatHit_d = 1'b0;
        beating_d = beating_q;
        period_d  = period_q;
        pvalid_d  = pvalid_q;

        if (bus.iPow_valid) begin
            acc_d = acc_q - (acc_q >> AVG_SHIFT) + ACC_W'(bus.iPow);
            if (!warmed) begin
                warm_d = warm_q + WARM_W'(1);
            end
        end

        case (state_q)
            LISTEN: begin
                if (detectCond) begin
                    state_d   = HOLD;
                    beatHit_d = 1'b1;
                end
            end
            HOLD: begin
                if (k == HOLD_K) begin
                    state_d = LISTEN;
                end
            end
            default: state_d = LISTEN;
        endcase

        if (beatHit_d) begin
            tic_d = '0;
        end else if (!(&tic_q)) begin
            tic_d = PERIOD_W'(k);
        end

        // A beat on the timeout edge wins but is treated like a first beat,
        // so beating is cleared on every non-qualifying beat.
        if (beatHit_d) begin
            if (had_q && (k < TIMEOUT_K)) begin
`ifdef BEAT_PERIOD_AVG_EN
                if (pvalid_q) begin
                    period_d = PERIOD_W'(periodSum >> 1);
                end else begin
                    period_d = PERIOD_W'(k);
                end
`else
                period_d = PERIOD_W'(k);
`endif
                pvalid_d  = 1'b1;
                beating_d = 1'b1;
            end else begin
                had_d     = 1'b1;
                beating_d = 1'b0;
            end
        end else if (k == TIMEOUT_K) begin
            beating_d = 1'b0;
            had_d     = 1'b0;
        end
    end

    // State register: every piece of tracker state, cleared asynchronously
    // so a reset mid-beat drops the outputs immediately.
    always_ff @(posedge aud_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= LISTEN;
            acc_q     <= '0;
            warm_q    <= '0;
            tic_q     <= '0;
            had_q     <= 1'b0;
            beatHit_q <= 1'b0;
            beating_q <= 1'b0;
            period_q  <= '0;
            pvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            warm_q    <= warm_d;
            tic_q     <= tic_d;
            had_q     <= had_d;
            beatHit_q <= beatHit_d;
            beating_q <= beating_d;
            period_q  <= period_d;
            pvalid_q  <= pvalid_d;
        end
    end

    assign bus.beatHit           = beatHit_q;
    assign bus.beating           = beating_q;
    assign bus.aud_tics_per_beat = period_q;
    assign bus.period_valid      = pvalid_q;

endmodule
